// File: rtl/sync_down_counter_pkg.sv
// rtl/sync_down_counter_pkg.sv - shared state type and mode constants for sync_down_counter
package sync_down_counter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - programmable down-counter with one-shot/auto-reload and terminal-count pulse
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero;

  assign zero = ~|count_q;

  // Branch order encodes edge priority: load > stop > start > count.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load_i) begin
      reload_d = load_val_i;
      count_d  = load_val_i;
      state_d  = IDLE;
    end else if (stop_i && state_q == RUN) begin
      state_d = IDLE;
    end else if (start_i && state_q == IDLE) begin
      state_d = RUN;
    end else if (start_i && state_q == DONE) begin
      count_d = reload_q;
      state_d = RUN;
    end else if (state_q == RUN && en_i) begin
      if (!zero) begin
        count_d = count_q - ONE;
      end else begin
        tc_d = 1'b1;
        if (mode_i == MODE_RELOAD) count_d = reload_q;
        else                       state_d = DONE;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign q_o    = count_q;
  assign tc_o   = tc_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - scoreboard bench for sync_down_counter (WIDTH 4 and 8 instances)
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [7:0] load_val8 = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;

  logic [3:0] q4;
  logic       tc4, busy4, done4;
  logic [7:0] q8;
  logic       tc8, busy8, done8;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_val_i(load_val),
    .start_i(start), .stop_i(stop), .en_i(en), .mode_i(mode),
    .q_o(q4), .tc_o(tc4), .busy_o(busy4), .done_o(done4)
  );

  sync_down_counter #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_val_i(load_val8),
    .start_i(start), .stop_i(stop), .en_i(en), .mode_i(mode),
    .q_o(q8), .tc_o(tc8), .busy_o(busy8), .done_o(done8)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard monitor: compares each queued expectation one step after its edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc_n) begin
        errors++;
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc_n);
      end else if ({q4, tc4, busy4, done4} !== {e.q, e.tc, e.busy, e.done}) begin
        errors++;
        $display("FAIL %s: got q=%0d tc=%0b busy=%0b done=%0b, want q=%0d tc=%0b busy=%0b done=%0b",
                 e.name, q4, tc4, busy4, done4, e.q, e.tc, e.busy, e.done);
      end
    end
  end

  task automatic drive(input logic ld, input logic [3:0] lv, input logic st,
                       input logic sp, input logic e, input logic m);
    @(negedge clk);
    rst = 1'b0; load = ld; load_val = lv; start = st; stop = sp; en = e; mode = m;
  endtask

  task automatic expect_next(input logic [3:0] q, input logic tc, input logic busy,
                             input logic done, input string name);
    exp_t x;
    x.cyc = cyc_n + 1; x.q = q; x.tc = tc; x.busy = busy; x.done = done; x.name = name;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0;
      expect_next(4'd0, 1'b0, 1'b0, 1'b0, "reset");
    end
  endtask

  task automatic test_auto_reload();
    drive(1, 4'd3, 0, 0, 0, 1); expect_next(4'd3, 0, 0, 0, "ar_load");
    drive(0, 4'd0, 1, 0, 1, 1); expect_next(4'd3, 0, 1, 0, "ar_start");
    for (int i = 1; i <= 9; i++) begin
      logic [3:0] eq;
      eq = 4'(3 - (i % 4));
      drive(0, 4'd0, 0, 0, 1, 1);
      expect_next(eq, (i % 4) == 0, 1'b1, 1'b0, "ar_count");
    end
  endtask

  task automatic test_one_shot();
    drive(1, 4'd2, 0, 0, 0, 0); expect_next(4'd2, 0, 0, 0, "os_load");
    drive(0, 4'd0, 1, 0, 1, 0); expect_next(4'd2, 0, 1, 0, "os_start");
    drive(0, 4'd0, 0, 0, 1, 0); expect_next(4'd1, 0, 1, 0, "os_cnt1");
    drive(0, 4'd0, 0, 0, 1, 0); expect_next(4'd0, 0, 1, 0, "os_cnt0");
    drive(0, 4'd0, 0, 0, 1, 0); expect_next(4'd0, 1, 0, 1, "os_tc");
    drive(0, 4'd0, 0, 0, 1, 0); expect_next(4'd0, 0, 0, 1, "os_hold");
    drive(0, 4'd0, 1, 0, 1, 0); expect_next(4'd2, 0, 1, 0, "os_restart");
  endtask

  task automatic test_enable_gating();
    drive(1, 4'd3, 0, 0, 0, 1); expect_next(4'd3, 0, 0, 0, "eg_load");
    drive(0, 4'd0, 1, 0, 0, 1); expect_next(4'd3, 0, 1, 0, "eg_start");
    for (int i = 1; i <= 16; i++) begin
      int k;
      logic e;
      e = (i % 2) == 1;
      k = (i + 1) / 2;
      drive(0, 4'd0, 0, 0, e, 1);
      expect_next(4'(3 - (k % 4)), e && (k % 4) == 0, 1'b1, 1'b0, "eg_count");
    end
  endtask

  task automatic test_priority();
    drive(1, 4'd5, 0, 0, 0, 1); expect_next(4'd5, 0, 0, 0, "pr_load5");
    drive(0, 4'd0, 1, 0, 0, 1); expect_next(4'd5, 0, 1, 0, "pr_start");
    drive(0, 4'd0, 1, 1, 1, 1); expect_next(4'd5, 0, 0, 0, "pr_stop_over_start");
    drive(1, 4'd1, 0, 0, 0, 1); expect_next(4'd1, 0, 0, 0, "pr_load1");
    drive(0, 4'd0, 1, 0, 1, 1); expect_next(4'd1, 0, 1, 0, "pr_start1");
    drive(0, 4'd0, 0, 0, 1, 1); expect_next(4'd0, 0, 1, 0, "pr_at_zero");
    drive(1, 4'd9, 0, 0, 1, 1); expect_next(4'd9, 0, 0, 0, "pr_load_over_tc");
    drive(1, 4'd0, 0, 0, 0, 1); expect_next(4'd0, 0, 0, 0, "pr_load0");
    drive(0, 4'd0, 1, 0, 1, 1); expect_next(4'd0, 0, 1, 0, "pr_start0");
    drive(0, 4'd0, 0, 1, 1, 1); expect_next(4'd0, 0, 0, 0, "pr_stop_over_tc");
  endtask

  task automatic test_reset_mid();
    drive(1, 4'd7, 0, 0, 0, 1); expect_next(4'd7, 0, 0, 0, "rm_load");
    drive(0, 4'd0, 1, 0, 0, 1); expect_next(4'd7, 0, 1, 0, "rm_start");
    drive(0, 4'd0, 0, 0, 1, 1); expect_next(4'd6, 0, 1, 0, "rm_count");
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    expect_next(4'd0, 0, 0, 0, "rm_reset");
    drive(0, 4'd0, 1, 0, 1, 1); expect_next(4'd0, 0, 1, 0, "rm_start_zero");
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'd0, 0, 0, 1, 1); expect_next(4'd0, 1, 1, 0, "rm_tc_held");
    end
  endtask

  task automatic test_width_boundary();
    int t4[$];
    int t8[$];
    drive(1, 4'd15, 0, 0, 0, 1);
    load_val8 = 8'd255;
    expect_next(4'd15, 0, 0, 0, "wb_load");
    drive(0, 4'd0, 1, 0, 1, 1);
    expect_next(4'd15, 0, 1, 0, "wb_start");
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'd255 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL wb_start8: got q=%0d busy=%0b, want q=255 busy=1", q8, busy8);
    end
    for (int i = 1; i <= 520; i++) begin
      drive(0, 4'd0, 0, 0, 1, 1);
      @(posedge clk); #1;
      if (tc4) t4.push_back(i);
      if (tc8) t8.push_back(i);
    end
    checks++;
    if (t4.size() < 2 || t4[0] != 16 || t4[1] != 32) begin
      errors++;
      $display("FAIL wb_period16: got %0d pulses first=%0d, want first=16 second=32",
               t4.size(), (t4.size() > 0) ? t4[0] : -1);
    end
    checks++;
    if (t4.size() != 32) begin
      errors++;
      $display("FAIL wb_count16: got %0d pulses, want 32", t4.size());
    end
    checks++;
    if (t8.size() != 2 || t8[0] != 256 || t8[1] != 512) begin
      errors++;
      $display("FAIL wb_period256: got %0d pulses first=%0d, want 2 pulses at 256 and 512",
               t8.size(), (t8.size() > 0) ? t8[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_enable_gating();
    test_priority();
    test_reset_mid();
    test_width_boundary();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Programmable synchronous down-counter with one-shot and auto-reload modes, WIDTH bits wide. It is the count-down companion to the team's free-running synchronous up-counter. Software or an upstream FSM loads a value, starts the count, and the block raises a one-cycle terminal-count pulse on reaching zero. Typical uses are timeouts, event divide-by-N (N = load+1), and periodic clock-enable generation inside the Counters_Dividers library.

## Interface
- WIDTH, 4: counter and load-value width, ≥2.
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- load_i  input  1  load load_val_i into the reload register and q_o.
- load_val_i  input  WIDTH  value captured on load_i.
- start_i  input  1  begin or resume counting.
- stop_i  input  1  pause counting.
- en_i  input  1  count enable; one decrement per enabled cycle.
- mode_i  input  1  0 = one-shot, 1 = auto-reload; sampled at each terminal event.
- q_o  output  WIDTH  current count.
- tc_o  output  1  registered terminal-count pulse.
- busy_o  output  1  high in RUN.
- done_o  output  1  high in DONE (one-shot expired).

## Operation
- States: IDLE, RUN, DONE.
- The internal reload register holds WIDTH bits and is written only by load_i.
- Per-edge priority: rst_i > load_i > stop_i > start_i > count.
- rst_i: q_o=0, reload=0, state IDLE, tc_o=0, busy_o=0, done_o=0.
- load_i (any state): reload and q_o ← load_val_i; state → IDLE.
- stop_i in RUN: state → IDLE; q_o holds. stop_i in IDLE or DONE has no effect.
- start_i in IDLE: state → RUN; q_o unchanged, so the count resumes from the current value.
- start_i in DONE: q_o ← reload; state → RUN.
- start_i in RUN: ignored.
- RUN, en_i=1, q_o≠0: q_o ← q_o−1 (modulo arithmetic is never needed).
- RUN, en_i=1, q_o=0 (terminal event):
  - tc_o ← 1.
  - If mode_i=1: q_o ← reload and the state stays RUN.
  - If mode_i=0: q_o stays 0 and state → DONE.
- RUN, en_i=0: q_o holds; no event.
- tc_o is 0 on every edge that is not a terminal event. It never stays high for two cycles unless consecutive edges are terminal events (reload=0, auto-reload, en_i=1).
- A terminal event is pre-empted if load_i or stop_i is asserted on the same edge; tc_o stays 0.
- busy_o and done_o are decoded from the registered state and are glitch-free.

## Timing
- All outputs are registered and change only on the rising edge of clk_i.
- Reset takes effect on the first edge with rst_i=1. rst_i mid-count aborts with no tc_o.
- Auto-reload with reload=N and en_i held high gives a tc_o period of N+1 cycles. With reload=0, tc_o is held high.
- One-shot from load N: start edge, then N+1 enabled edges until tc_o=1 with done_o=1 on that same edge.
- Load-to-count latency is 1 cycle: load_i at edge k, start_i at edge k+1, first decrement at edge k+2 if en_i=1.

## Structure
- Package sync_down_counter_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - constants MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1.
- Single module with no sub-module. It contains the state register, next-state logic, the count datapath with zero detect, and the reload register.
- The zero compare is a WIDTH-wide reduction NOR on q_o.

## Test plan
- Auto-reload: load 3, start, en=1, mode=1 → q_o 3,2,1,0,3,2…; tc_o high every 4th cycle, aligned with q_o returning to 3.
- One-shot: load 2, start, en=1, mode=0 → q_o 2,1,0, then tc_o one pulse and done_o=1; q_o stays 0. A second start gives q_o=2 and RUN again.
- Enable gating: load 3, auto-reload, en_i alternating 1/0 → tc_o every 8 cycles; q_o holds on en_i=0 cycles.
- Priority:
  - stop_i and start_i on the same edge in RUN at q_o=5 → IDLE, q_o=5.
  - load_i=9 during RUN with q_o=0, en=1 → IDLE, q_o=9, tc_o=0.
- Reset mid-operation: RUN at q_o=6, rst_i one cycle → q_o=0, busy_o=0, done_o=0, tc_o=0. A subsequent start with reload=0 in mode 1 drives tc_o high every enabled cycle.
- Width boundary: WIDTH=4, load 15, auto-reload → period 16. WIDTH=8, load 255 → period 256.
